// File: rtl/regfile_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : regfile_stream_reader
// Purpose  : Walks an inclusive address range [lo,hi] on one combinational
//            register-file read port and streams {addr,data,last} beats out
//            on a valid/ready interface through a 2-entry in-order buffer.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_stream_reader #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_en,
   input  logic [ADDR_WIDTH-1:0] start_lo,
   input  logic [ADDR_WIDTH-1:0] start_hi,
   output logic                  start_rdy,
   input  logic                  abort_en,
   output logic [ADDR_WIDTH-1:0] rf_addr,
   input  logic [DATA_WIDTH-1:0] rf_data,
   output logic                  out_valid,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done
);

   // Buffer entry layout: {addr, data, last}
   localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] cur;
   logic [ADDR_WIDTH-1:0] last_addr;
   logic [ENTRY_W-1:0]    slot0;
   logic [ENTRY_W-1:0]    slot1;
   logic [ENTRY_W-1:0]    push_entry;
   logic [1:0]            count;
   logic                  done_q;
   logic                  done_nxt;
   logic                  pop;
   logic                  push;
   logic                  at_hi;
   logic                  abort_act;
   logic                  start_ok;

   // The end test compares before incrementing, so hi = all-ones never wraps.
   assign at_hi      = (cur == last_addr);
   assign pop        = out_valid & out_ready;
   assign abort_act  = abort_en & (state != ST_IDLE);
   assign start_ok   = start_en & (state == ST_IDLE) & (start_lo <= start_hi);
   // A full buffer still accepts a push when the head leaves in the same cycle.
   assign push       = (state == ST_RUN) & ~abort_en & ((count != 2'd2) | pop);
   assign push_entry = {cur, rf_data, at_hi};

   assign out_valid  = (count != 2'd0);
   assign out_addr   = slot0[ENTRY_W-1 -: ADDR_WIDTH];
   assign out_data   = slot0[DATA_WIDTH:1];
   assign out_last   = out_valid & slot0[0];
   // The walk pointer only moves in RUN, so it doubles as the held read address.
   assign rf_addr    = cur;
   assign busy       = (state != ST_IDLE);
   assign start_rdy  = (state == ST_IDLE);
   assign done       = done_q;

   // Next-state and completion-pulse decode.
   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_ok) begin
               state_nxt = ST_RUN;
            end else if (start_en && (start_lo > start_hi)) begin
               done_nxt = 1'b1;
            end
         end
         ST_RUN: begin
            if (abort_act) begin
               state_nxt = ST_IDLE;
            end else if (push && at_hi) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (abort_act) begin
               state_nxt = ST_IDLE;
            end else if (pop && (count == 2'd1)) begin
               state_nxt = ST_IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register, walk pointer/limit and completion pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cur       <= '0;
         last_addr <= '0;
         done_q    <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= done_nxt;
         if (start_ok) begin
            cur       <= start_lo;
            last_addr <= start_hi;
         end else if (push && !at_hi) begin
            cur <= cur + 1'b1;
         end
      end
   end

   // Two-entry in-order buffer; slot0 is always the head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot0 <= '0;
         slot1 <= '0;
         count <= 2'd0;
      end else if (abort_act) begin
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  slot0 <= push_entry;
               end else begin
                  slot1 <= push_entry;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               slot0 <= slot1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  slot0 <= push_entry;
               end else begin
                  slot0 <= slot1;
                  slot1 <= push_entry;
               end
            end
            default: begin
               count <= count;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
